// File: rtl/step_seq.sv
`default_nettype none
// ============================================================================
//  Module      : step_seq
//  Description : Machine-cycle step sequencer. A phase counter walks four
//                clk ticks per machine cycle and emits registered enable
//                (clk_e) and set (clk_s) strobes. A one-hot step register
//                advances at each cycle boundary and wraps from step 6 to
//                step 1.
//  Options     : define STEP_SEQ_SINGLE_STEP_EN to let a step_req pulse
//                start one machine cycle while run=0 and the block is idle.
//  Revision    : 1.0 - initial release
// ============================================================================
module step_seq #(
   parameter int PHASES = 4
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       run,
   input  logic       step_req,
   output logic       clk_e,
   output logic       clk_s,
   output logic [5:0] step,
   output logic       busy
);

   localparam int                 c_PH_W     = $clog2(PHASES);
   localparam logic [c_PH_W-1:0]  c_PH_FIRST = '0;
   localparam logic [c_PH_W-1:0]  c_PH_SET   = c_PH_W'(1);
   localparam logic [c_PH_W-1:0]  c_PH_LAST  = c_PH_W'(PHASES - 1);
   localparam logic [5:0]         c_STEP1    = 6'b000001;

   // S_SYNC is the single synchronising edge after reset release; no cycle
   // may start from it, which gives the two-edge start latency.
   typedef enum logic [1:0] {
      S_SYNC  = 2'd0,
      S_IDLE  = 2'd1,
      S_CYCLE = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [c_PH_W-1:0]   ph_q, ph_d;
   logic [5:0]          step_q, step_d;
   logic                clk_e_q, clk_e_d;
   logic                clk_s_q, clk_s_d;

   logic                start_cycle;
   logic                step_legal;
   logic [5:0]          step_next;

`ifdef STEP_SEQ_SINGLE_STEP_EN
   // step_req is only consulted from idle, so it is naturally ignored while
   // a cycle is in progress; with run=1 the cycle starts anyway.
   assign start_cycle = run | step_req;
`else
   // Sequencing is governed by run alone; step_req is kept on the port list
   // for pin compatibility.
   logic unused_step_req;
   assign unused_step_req = step_req;
   assign start_cycle     = run;
`endif

   // A non-one-hot step (e.g. after an upset) restarts at step 1 on the
   // next boundary; otherwise rotate, so step 6 wraps straight to step 1.
   assign step_legal = (step_q != 6'd0) && ((step_q & (step_q - 6'd1)) == 6'd0);
   assign step_next  = step_legal ? {step_q[4:0], step_q[5]} : c_STEP1;

   // Next-state logic: phase walk, boundary handling and strobe decode.
   always_comb begin
      state_d = state_q;
      ph_d    = ph_q;
      step_d  = step_q;
      clk_e_d = 1'b0;
      clk_s_d = 1'b0;

      case (state_q)
         S_SYNC: begin
            state_d = S_IDLE;
         end
         S_IDLE: begin
            if (start_cycle) begin
               state_d = S_CYCLE;
               ph_d    = c_PH_FIRST;
            end
         end
         S_CYCLE: begin
            if (ph_q == c_PH_LAST) begin
               // Boundary: run is sampled only here, so dropping it
               // mid-cycle never truncates the cycle in progress.
               step_d = step_next;
               if (run) begin
                  ph_d = c_PH_FIRST;
               end else begin
                  state_d = S_IDLE;
               end
            end else begin
               ph_d = ph_q + 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
            ph_d    = c_PH_LAST;
         end
      endcase

      // Strobes are decoded from the next state so they leave the flops
      // aligned with the phase they describe; clk_s sits inside clk_e.
      clk_e_d = (state_d == S_CYCLE) && (ph_d != c_PH_LAST);
      clk_s_d = (state_d == S_CYCLE) && (ph_d == c_PH_SET);
   end

   // State and output registers; reset aborts any cycle immediately.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_SYNC;
         ph_q    <= c_PH_LAST;
         step_q  <= c_STEP1;
         clk_e_q <= 1'b0;
         clk_s_q <= 1'b0;
      end else begin
         state_q <= state_d;
         ph_q    <= ph_d;
         step_q  <= step_d;
         clk_e_q <= clk_e_d;
         clk_s_q <= clk_s_d;
      end
   end

   assign clk_e = clk_e_q;
   assign clk_s = clk_s_q;
   assign step  = step_q;
   assign busy  = (state_q == S_CYCLE);

endmodule
`default_nettype wire

// File: tb/tb_step_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_step_seq
//  Description : Scoreboard bench for step_seq. The driver predicts each
//                clock's outputs from a machine-cycle model and queues them;
//                the monitor pops and compares after every rising edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_step_seq;

`ifdef STEP_SEQ_SINGLE_STEP_EN
   localparam bit c_SS = 1'b1;
`else
   localparam bit c_SS = 1'b0;
`endif

   logic       clk;
   logic       reset_n;
   logic       run;
   logic       step_req;
   logic       clk_e;
   logic       clk_s;
   logic [5:0] step;
   logic       busy;

   typedef struct packed {
      logic       e;
      logic       s;
      logic [5:0] st;
      logic       b;
   } exp_t;

   exp_t q[$];
   int   n_chk = 0;
   int   n_bad = 0;
   int   obs_pulses = 0;

   // Reference model: position inside the machine cycle (-1 = idle),
   // step index 0..5, and whether the post-reset sync edge has passed.
   int   m_pos;
   int   m_step;
   bit   m_synced;

   // Small TMP register loaded by clk_s during step 4.
   logic [7:0] t_in, t_out;

   step_seq #(.PHASES(4)) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .run      (run),
      .step_req (step_req),
      .clk_e    (clk_e),
      .clk_s    (clk_s),
      .step     (step),
      .busy     (busy)
   );

   assign t_in = step[3] ? 8'h55 : 8'haa;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n)             t_out <= 8'h00;
      else if (clk_s && step[3]) t_out <= t_in;
   end

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_edge(input logic r, input logic sr);
      bit go;
      go = r || (sr && c_SS);
      if (!m_synced) begin
         m_synced = 1'b1;
      end else if (m_pos < 0) begin
         if (go) m_pos = 0;
      end else if (m_pos < 3) begin
         m_pos = m_pos + 1;
      end else begin
         m_step = (m_step + 1) % 6;
         m_pos  = r ? 0 : -1;
      end
   endtask

   // Called at a falling edge: apply inputs for the coming rising edge,
   // queue the predicted outputs, and return at the following falling edge.
   task automatic drive_cycle(input logic r, input logic sr);
      exp_t e;
      run      = r;
      step_req = sr;
      model_edge(r, sr);
      e.e  = (m_pos >= 0) && (m_pos < 3);
      e.s  = (m_pos == 1);
      e.st = 6'(1 << m_step);
      e.b  = (m_pos >= 0);
      q.push_back(e);
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset_n  = 1'b0;
      run      = 1'b0;
      step_req = 1'b0;
      m_synced = 1'b0;
      m_pos    = -1;
      m_step   = 0;
      q.delete();
      #1;
      check("rst_clk_e", {7'd0, clk_e}, 8'd0);
      check("rst_clk_s", {7'd0, clk_s}, 8'd0);
      check("rst_step",  {2'd0, step},  8'h01);
      check("rst_busy",  {7'd0, busy},  8'd0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
   endtask

   // Monitor: compare every clock's outputs against the queued prediction.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (clk_s) obs_pulses++;
         if (q.size() > 0) begin
            e = q.pop_front();
            check("clk_e", {7'd0, clk_e}, {7'd0, e.e});
            check("clk_s", {7'd0, clk_s}, {7'd0, e.s});
            check("step",  {2'd0, step},  {2'd0, e.st});
            check("busy",  {7'd0, busy},  {7'd0, e.b});
            check("s_without_e", {7'd0, clk_s & ~clk_e}, 8'd0);
         end
      end
   end

   initial begin
      int p0;
      int guard;
      run      = 1'b0;
      step_req = 1'b0;
      reset_n  = 1'b1;
      #2;

      // Free-running walk through all six steps, plus TMP load at step 4.
      do_reset();
      p0 = obs_pulses;
      for (int i = 0; i < 26; i++) begin
         drive_cycle(1'b1, 1'b0);
         if (i == 0) check("sync_edge_no_start", {7'd0, clk_e}, 8'd0);
         if (i == 1) check("second_edge_start",  {7'd0, clk_e}, 8'd1);
         if (m_step == 2 && m_pos == 3) check("tmp_before_s4", t_out, 8'h00);
         if (m_step == 5 && m_pos == 3) check("tmp_held_s6",   t_out, 8'h55);
      end
      check("walk_pulses", 8'(obs_pulses - p0), 8'd6);

      // Drop run during ph1 of step 3: cycle completes, then idle at step 4.
      guard = 0;
      while (!(m_pos == 1 && m_step == 2) && guard < 100) begin
         drive_cycle(1'b1, 1'b0);
         guard++;
      end
      check("reach_s3_ph1", {7'd0, clk_s}, 8'd1);
      for (int i = 0; i < 8; i++) drive_cycle(1'b0, 1'b0);
      check("stop_step", {2'd0, step},  8'h08);
      check("stop_busy", {7'd0, busy},  8'd0);
      check("stop_clk_e", {7'd0, clk_e}, 8'd0);

      // Reset during ph1 of step 5 drops strobes without a clock edge.
      do_reset();
      guard = 0;
      while (!(m_pos == 1 && m_step == 4) && guard < 100) begin
         drive_cycle(1'b1, 1'b0);
         guard++;
      end
      check("pre_reset_clk_s", {7'd0, clk_s}, 8'd1);
      check("pre_reset_step",  {2'd0, step},  8'h10);
      p0 = obs_pulses;
      do_reset();
      check("no_pulse_in_reset", 8'(obs_pulses - p0), 8'd0);

      // step_req pulses with run=0, one extra issued while busy.
      drive_cycle(1'b0, 1'b0);
      p0 = obs_pulses;
      for (int k = 0; k < 3; k++) begin
         drive_cycle(1'b0, 1'b1);
         repeat (2) drive_cycle(1'b0, 1'b0);
         drive_cycle(1'b0, 1'b1);
         repeat (4) drive_cycle(1'b0, 1'b0);
      end
      check("single_step_pulses", 8'(obs_pulses - p0), c_SS ? 8'd3 : 8'd0);
      check("single_step_final",  {2'd0, step},        c_SS ? 8'h08 : 8'h01);

      // Randomised run / step_req traffic.
      do_reset();
      for (int i = 0; i < 400; i++) begin
         drive_cycle(($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
                     ($urandom_range(0, 5) == 0) ? 1'b1 : 1'b0);
      end
      for (int i = 0; i < 40; i++) begin
         drive_cycle(1'b0, ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0);
      end
      check("queue_drained", 8'(q.size()), 8'd0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/step_seq.md
STEP_SEQ -- requirements
Module: step_seq

Interface
REQ-001 Parameter PHASES, default 4: clk ticks per machine cycle; fixed at 4, other values unsupported.
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 run  input  1  level; 1 = free-running sequencing, 0 = hold at next cycle boundary.
REQ-005 step_req  input  1  single-cycle pulse; requests exactly one machine cycle while run=0 (see Configuration).
REQ-006 clk_e  output  1  enable phase; registered; drives register enable onto bus.
REQ-007 clk_s  output  1  set phase; registered; strobes register set inputs (e.g. TMP s).
REQ-008 step  output  6  one-hot current step, bit0 = step 1 ... bit5 = step 6.
REQ-009 busy  output  1  1 while a machine cycle is in progress (phase counter not idle).

Function
REQ-010 Internal 2-bit phase counter ph advances 0->1->2->3->0 once per clk while a cycle is active.
REQ-011 Phase decode (registered, no combinational path from inputs): ph0 clk_e=1 clk_s=0; ph1 clk_e=1 clk_s=1; ph2 clk_e=1 clk_s=0; ph3 clk_e=0 clk_s=0.
REQ-012 clk_s SHALL never be 1 when clk_e is 0; clk_s is exactly one clk wide per machine cycle.
REQ-013 Step advances only on the ph3->ph0 transition: step<<1, step 6 -> step 1 (step 7 is an implicit reset, never visible on step).
REQ-014 A new cycle starts at ph0 in the clk following the boundary if run=1; otherwise the block idles with ph=3 state, clk_e=0, clk_s=0, step held.
REQ-015 run deasserted mid-cycle SHALL NOT truncate the cycle; current cycle completes through ph3, then idle.
REQ-016 run reasserted while idle: first ph0 appears on the next clk edge (1-cycle latency).
REQ-017 step SHALL always be one-hot; any illegal value (e.g. upset) recovers to step 1 at the next boundary.
REQ-018 busy=1 during ph0..ph3 of an active cycle, 0 while idle.
REQ-019 step_req while run=1 or while busy=1 is ignored (not queued).

Reset
REQ-020 reset_n=0 asynchronously forces: step=6'b000001, ph idle, clk_e=0, clk_s=0, busy=0.
REQ-021 Reset mid-cycle aborts the cycle immediately; no clk_s pulse is emitted after reset asserts.
REQ-022 After reset_n deasserts with run=1, first ph0 (clk_e=1) appears on the second rising clk edge following release (one synchronising edge, then start).

Configuration
REQ-023 Macro STEP_SEQ_SINGLE_STEP_EN: when defined, step_req with run=0 and busy=0 starts exactly one full machine cycle (ph0..ph3, one clk_s pulse, step advance at end), then idles.
REQ-024 Without STEP_SEQ_SINGLE_STEP_EN, step_req is ignored entirely (port retained, unused) and sequencing is controlled by run only.

Verification
REQ-025 Reset then run=1 for 24 clk -> step walks 000001,000010,...,100000,000001; clk_e pattern 1,1,1,0 repeating; clk_s high only on ph1; six clk_s pulses.
REQ-026 run=1, drop run during ph1 of step 3 -> cycle completes, step becomes 000100->001000 at boundary, then clk_e=0, busy=0, step held at 001000.
REQ-027 Assert reset_n=0 during ph1 of step 5 (clk_s=1) -> clk_s, clk_e drop same instant (no clock edge), step=000001.
REQ-028 With STEP_SEQ_SINGLE_STEP_EN, run=0, three step_req pulses spaced 8 clk -> exactly three clk_s pulses, step 000001->000010->000100->001000; step_req issued while busy=1 produces no extra cycle.
REQ-029 System check: clk_s wired to tmp s, t_in=8'h55 on bus during step 4 -> tmp t_out=8'h55 after step-4 clk_s pulse, unchanged (8'h55) through steps 5-6 with t_in changed to 8'haa.
